mmio_timer: RTL and testbench

- Memory-mapped timer peripheral; the responder on the core's load/store data port (address = ALU result, write data = rs2 value, write enable = MemWrite, access mode = modeBU).
- Sits beside data_memory. Top-level muxes `rd_data` into the load result when `hit` is high, and routes `irq` to the core/testbench.
- Provides a prescaled up-counter, a compare match with optional auto-reload, and sticky status flags.

---
 rtl/timer_pkg.sv | 26 ++
 rtl/timer_prescaler.sv | 21 ++
 rtl/mmio_timer.sv | 131 +++++++++++++
 tb/tb_mmio_timer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared register map, bit positions and control type for the mmio_timer peripheral.
package timer_pkg;
   localparam logic [4:0] OFF_CTRL    = 5'h00;
   localparam logic [4:0] OFF_COUNT   = 5'h04;
   localparam logic [4:0] OFF_COMPARE = 5'h08;
   localparam logic [4:0] OFF_STATUS  = 5'h0C;
   localparam logic [4:0] OFF_CAPTURE = 5'h10;

   localparam int CTRL_EN           = 0;
   localparam int CTRL_AUTORELOAD   = 1;
   localparam int CTRL_IRQEN        = 2;
   localparam int CTRL_PRESCALE_LSB = 8;

   localparam int ST_MATCH = 0;
   localparam int ST_OVF   = 1;
   localparam int ST_CAP   = 2;
   localparam int ST_ERR   = 3;

   localparam logic [2:0] MODE_WORD = 3'b010;

   typedef struct packed {
      logic irqen;
      logic autoreload;
      logic en;
   } ctrl_t;
endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock: one-cycle tick every (prescale + 1) enabled cycles.
module timer_prescaler #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  restart,
   output logic                  tick
);
   logic [PRESCALE_W-1:0] cnt;

   assign tick = en & (cnt == prescale);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        cnt <= '0;
      else if (restart || !en || tick) cnt <= '0;
      else                             cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload and W1C status.
// Define TIMER_CAPTURE_EN to add the synchronized input-capture register at 0x10.
module mmio_timer
   import timer_pkg::*;
#(
   parameter int              WIDTH      = 32,
   parameter logic [WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
   parameter int              PRESCALE_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wd,
   input  logic             we,
   input  logic             re,
   input  logic [2:0]       mode_bu,
   output logic [WIDTH-1:0] rd_data,
   output logic             hit,
   output logic             irq,
   input  logic             capture_in
);
   logic [2:0]            idx;
   logic                  word_wr, bad_wr;
   logic                  wr_ctrl, wr_count, wr_compare, wr_status;
   ctrl_t                 ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [WIDTH-1:0]      count, compare, capture, count_inc;
   logic [3:0]            status, st_set, st_clr;
   logic                  tick, restart, cnt_match, reload, set_match, set_ovf, cap_evt;

   assign hit        = (addr[WIDTH-1:5] == BASE_ADDR[WIDTH-1:5]);
   assign idx        = addr[4:2];
   assign word_wr    = hit & we & (mode_bu == MODE_WORD);
   assign bad_wr     = hit & we & (mode_bu != MODE_WORD);
   assign wr_ctrl    = word_wr & (idx == OFF_CTRL[4:2]);
   assign wr_count   = word_wr & (idx == OFF_COUNT[4:2]);
   assign wr_compare = word_wr & (idx == OFF_COMPARE[4:2]);
   assign wr_status  = word_wr & (idx == OFF_STATUS[4:2]);

   assign restart = wr_ctrl & (wd[CTRL_PRESCALE_LSB +: PRESCALE_W] != prescale);

   timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (ctrl.en),
      .prescale (prescale),
      .restart  (restart),
      .tick     (tick)
   );

   // A software COUNT write pre-empts the tick, including its match evaluation.
   assign cnt_match = (count == compare);
   assign reload    = cnt_match & ctrl.autoreload;
   assign count_inc = count + 1'b1;
   assign set_match = tick & ~wr_count & cnt_match;
   assign set_ovf   = tick & ~wr_count & (&count) & ~reload;

   always_comb begin
      st_set           = '0;
      st_set[ST_MATCH] = set_match;
      st_set[ST_OVF]   = set_ovf;
      st_set[ST_CAP]   = cap_evt;
      st_set[ST_ERR]   = bad_wr;
   end
   assign st_clr = wr_status ? wd[3:0] : 4'b0;

`ifdef TIMER_CAPTURE_EN
   logic [2:0] cap_sync;
   logic       unused_bits;
   assign unused_bits = ^addr[1:0];
   assign cap_evt     = cap_sync[1] & ~cap_sync[2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_sync <= '0;
         capture  <= '0;
      end else begin
         cap_sync <= {cap_sync[1:0], capture_in};
         if (cap_evt) capture <= count;
      end
   end
`else
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], capture_in};
   assign cap_evt     = 1'b0;
   assign capture     = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl     <= '0;
         prescale <= '0;
         count    <= '0;
         compare  <= '1;
         status   <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            ctrl.en         <= wd[CTRL_EN];
            ctrl.autoreload <= wd[CTRL_AUTORELOAD];
            ctrl.irqen      <= wd[CTRL_IRQEN];
            prescale        <= wd[CTRL_PRESCALE_LSB +: PRESCALE_W];
         end
         if (wr_compare) compare <= wd;
         if (wr_count)   count <= wd;
         else if (tick)  count <= reload ? '0 : count_inc;
         // Hardware set beats a simultaneous write-1-to-clear.
         status <= (status & ~st_clr) | st_set;
         irq    <= ctrl.irqen & status[ST_MATCH];
      end
   end

   always_comb begin
      rd_data = '0;
      if (hit & re) begin
         case (idx)
            OFF_CTRL[4:2]: begin
               rd_data[CTRL_EN]                           = ctrl.en;
               rd_data[CTRL_AUTORELOAD]                   = ctrl.autoreload;
               rd_data[CTRL_IRQEN]                        = ctrl.irqen;
               rd_data[CTRL_PRESCALE_LSB +: PRESCALE_W]   = prescale;
            end
            OFF_COUNT[4:2]:   rd_data = count;
            OFF_COMPARE[4:2]: rd_data = compare;
            OFF_STATUS[4:2]:  rd_data[3:0] = status;
            OFF_CAPTURE[4:2]: rd_data = capture;
            default:          rd_data = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios plus random bus traffic
// checked against a register-level reference model.
module tb_mmio_timer;
   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] A_CTRL = BASE + 32'h00, A_COUNT = BASE + 32'h04;
   localparam logic [31:0] A_CMP  = BASE + 32'h08, A_STAT  = BASE + 32'h0C;
   localparam logic [31:0] A_CAP  = BASE + 32'h10;

   logic        clk = 1'b0, rst;
   logic [31:0] addr, wd, rd_data;
   logic        we, re, hit, irq, capture_in;
   logic [2:0]  mode_bu;
   int          checks = 0, errors = 0;

   mmio_timer #(.WIDTH(32), .BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wd(wd), .we(we), .re(re),
      .mode_bu(mode_bu), .rd_data(rd_data), .hit(hit), .irq(irq), .capture_in(capture_in)
   );

   always #5 clk = ~clk;

   // Reference model: architectural register values
   logic        m_en, m_ar, m_ie, m_match, m_ovf, m_err, m_cap, m_irq;
   logic [7:0]  m_pre, m_ph;
   logic [31:0] m_cnt, m_cmp, m_capv;

   function automatic void m_reset();
      {m_en, m_ar, m_ie, m_match, m_ovf, m_err, m_cap, m_irq} = '0;
      m_pre = '0; m_ph = '0; m_cnt = '0; m_cmp = 32'hFFFF_FFFF; m_capv = '0;
   endfunction

   function automatic logic [31:0] mreg(input logic [2:0] i);
      case (i)
         3'd0:    return {16'h0, m_pre, 5'h0, m_ie, m_ar, m_en};
         3'd1:    return m_cnt;
         3'd2:    return m_cmp;
         3'd3:    return {28'h0, m_err, m_cap, m_ovf, m_match};
         3'd4:    return m_capv;
         default: return 32'h0;
      endcase
   endfunction

   function automatic void step();
      logic        h, ww, tick, cw, sm, so;
      logic [2:0]  i;
      logic [32:0] inc;
      logic [31:0] nc;
      logic [3:0]  clr;
      h    = (addr & 32'hFFFF_FFE0) == BASE;
      i    = addr[4:2];
      ww   = h && we && (mode_bu == 3'b010);
      tick = m_en && (m_ph == m_pre);
      cw   = ww && (i == 3'd1);
      inc  = {1'b0, m_cnt} + 33'd1;
      sm = 1'b0; so = 1'b0; nc = m_cnt;
      if (cw) nc = wd;
      else if (tick) begin
         if (m_cnt == m_cmp) begin
            sm = 1'b1;
            nc = m_ar ? 32'h0 : inc[31:0];
            so = !m_ar && inc[32];
         end else begin
            nc = inc[31:0];
            so = inc[32];
         end
      end
      m_irq = m_ie && m_match;
      m_ph  = (!m_en || tick) ? 8'd0 : m_ph + 8'd1;
      clr   = (ww && i == 3'd3) ? wd[3:0] : 4'h0;
      m_match = (m_match && !clr[0]) || sm;
      m_ovf   = (m_ovf && !clr[1]) || so;
      m_cap   = m_cap && !clr[2];
      m_err   = (m_err && !clr[3]) || (h && we && mode_bu != 3'b010);
      if (ww && i == 3'd0) begin
         if (wd[15:8] != m_pre) m_ph = 8'd0;
         m_en = wd[0]; m_ar = wd[1]; m_ie = wd[2]; m_pre = wd[15:8];
      end
      if (ww && i == 3'd2) m_cmp = wd;
      m_cnt = nc;
   endfunction

   always @(posedge clk) begin
      if (!rst) m_reset();
      else      step();
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m = 3'b010);
      addr = a; wd = d; mode_bu = m; we = 1'b1; re = 1'b0;
      cyc();
      we = 1'b0; mode_bu = 3'b010;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, output logic [31:0] v);
      logic [31:0] e;
      addr = a; re = 1'b1; #1;
      e = ((a & 32'hFFFF_FFE0) == BASE) ? mreg(a[4:2]) : 32'h0;
      v = rd_data;
      chk(tag, v, e);
      re = 1'b0;
   endtask

   initial begin
      logic [31:0] v, a, d;
      logic [2:0]  m;
      int op;
      rst = 1'b0; addr = '0; wd = '0; we = 1'b0; re = 1'b0; mode_bu = 3'b010; capture_in = 1'b0;
      m_reset();
      #22 rst = 1'b1;

      // Reset values
      rd("rst_ctrl", A_CTRL, v);  chk("rst_ctrl_k", v, 32'h0);
      rd("rst_count", A_COUNT, v); chk("rst_count_k", v, 32'h0);
      rd("rst_cmp", A_CMP, v);    chk("rst_cmp_k", v, 32'hFFFF_FFFF);
      rd("rst_stat", A_STAT, v);  chk("rst_stat_k", v, 32'h0);
      rd("rst_cap", A_CAP, v);    chk("rst_cap_k", v, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      addr = BASE + 32'h40; re = 1'b0; #1;
      chk("rd_idle_zero", rd_data, 32'h0);

      // Compare match with auto-reload and irq
      wr(A_CMP, 32'd5);
      wr(A_CTRL, 32'h0000_0007);
      for (int i = 1; i <= 5; i++) begin
         cyc();
         rd("cnt_run", A_COUNT, v); chk("cnt_run_k", v, i);
      end
      cyc();
      rd("cnt_reload", A_COUNT, v); chk("cnt_reload_k", v, 32'h0);
      rd("match_set", A_STAT, v);   chk("match_set_k", v, 32'h1);
      chk("irq_delay0", {31'b0, irq}, 32'h0);
      cyc();
      chk("irq_set", {31'b0, irq}, 32'h1);
      wr(A_STAT, 32'h1);
      chk("irq_hold", {31'b0, irq}, 32'h1);
      cyc();
      chk("irq_drop", {31'b0, irq}, 32'h0);

      // Prescale 3, wrap with OVF
      wr(A_CTRL, 32'h0000_0301);
      wr(A_COUNT, 32'hFFFF_FFFE);
      repeat (2) cyc();
      rd("pre_hold", A_COUNT, v); chk("pre_hold_k", v, 32'hFFFF_FFFE);
      cyc();
      rd("pre_tick", A_COUNT, v); chk("pre_tick_k", v, 32'hFFFF_FFFF);
      repeat (3) cyc();
      rd("pre_hold2", A_COUNT, v); chk("pre_hold2_k", v, 32'hFFFF_FFFF);
      cyc();
      rd("wrap", A_COUNT, v); chk("wrap_k", v, 32'h0);
      rd("ovf", A_STAT, v);   chk("ovf_k", v, 32'h2);

      // Non-word store and out-of-window store
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'hF);
      wr(A_COUNT, 32'h77);
      wr(A_COUNT, 32'h1234, 3'b000);
      rd("bad_cnt", A_COUNT, v); chk("bad_cnt_k", v, 32'h77);
      rd("err", A_STAT, v);      chk("err_k", v, 32'h8);
      addr = BASE + 32'h20; #1;
      chk("miss_hit", {31'b0, hit}, 32'h0);
      wr(BASE + 32'h20, 32'hDEAD_BEEF);
      wr(BASE + 32'h24, 32'hDEAD_BEEF);
      rd("miss_rd", BASE + 32'h24, v); chk("miss_rd_k", v, 32'h0);
      rd("miss_cmp", A_CMP, v);        chk("miss_cmp_k", v, 32'h5);
      rd("miss_cnt", A_COUNT, v);      chk("miss_cnt_k", v, 32'h77);

      // Simultaneous events
      wr(A_CTRL, 32'h1);
      wr(A_COUNT, 32'h100);
      rd("sw_wins", A_COUNT, v); chk("sw_wins_k", v, 32'h100);
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'hF);
      wr(A_CMP, 32'h10);
      wr(A_COUNT, 32'h10);
      wr(A_CTRL, 32'h1);
      wr(A_STAT, 32'h1);
      rd("set_wins", A_STAT, v); chk("set_wins_k", v, 32'h1);
      rd("set_cnt", A_COUNT, v); chk("set_cnt_k", v, 32'h11);
      wr(A_CTRL, 32'h0);
      wr(A_STAT, 32'hF);

      // Input capture
      wr(A_COUNT, 32'd42);
      capture_in = 1'b1;
      repeat (2) cyc();
      capture_in = 1'b0;
      repeat (4) cyc();
`ifdef TIMER_CAPTURE_EN
      m_capv = 32'd42; m_cap = 1'b1;
      rd("cap_val", A_CAP, v); chk("cap_val_k", v, 32'd42);
      rd("cap_flag", A_STAT, v); chk("cap_flag_k", v, 32'h4);
      wr(A_STAT, 32'h4);
      rd("cap_clr", A_STAT, v); chk("cap_clr_k", v, 32'h0);
`else
      rd("cap_val", A_CAP, v); chk("cap_val_k", v, 32'h0);
      rd("cap_flag", A_STAT, v); chk("cap_flag_k", v, 32'h0);
`endif

      // Reset mid-count
      wr(A_CTRL, 32'h5);
      wr(A_CMP, 32'h2);
      wr(A_COUNT, 32'h0);
      repeat (6) cyc();
      chk("pre_rst_irq", {31'b0, irq}, 32'h1);
      #2 rst = 1'b0; m_reset(); #1;
      chk("mid_rst_irq", {31'b0, irq}, 32'h0);
      rd("mid_rst_cnt", A_COUNT, v); chk("mid_rst_cnt_k", v, 32'h0);
      rd("mid_rst_cmp", A_CMP, v);   chk("mid_rst_cmp_k", v, 32'hFFFF_FFFF);
      rd("mid_rst_ctrl", A_CTRL, v); chk("mid_rst_ctrl_k", v, 32'h0);
      @(negedge clk) rst = 1'b1;
      #1;

      // Random traffic against the model
      repeat (400) begin
         op = $urandom_range(0, 5);
         a  = BASE + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         d  = $urandom;
         if (a[4:2] == 3'd0) d[15:8] = 8'($urandom_range(0, 3));
         if (a[4:2] == 3'd1 || a[4:2] == 3'd2)
            d = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
         case (op)
            0, 1: wr(a, d);
            2: begin
               m = 3'($urandom_range(0, 7));
               if (m == 3'b010) m = 3'b000;
               wr(a, d, m);
            end
            3: begin
               if ($urandom_range(0, 3) == 0) a = a ^ 32'h20;
               rd("rnd_rd", a, v);
            end
            4: wr(a ^ 32'h0000_0100, d);
            default: cyc();
         endcase
         chk("rnd_irq", {31'b0, irq}, {31'b0, m_irq});
         rd("rnd_cnt", A_COUNT, v);
         rd("rnd_stat", A_STAT, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
